tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Time-division demultiplexer. The inverse of the 4:1 mux datapath: one input
//  stream is spread across four registered output lanes Q0..Q3.
//  Two modes:
//  - TDM mode: a rotating slot counter, locked by a start-of-frame marker, assigns samples to lanes.
//  - Addressed mode: a 2-bit select (A1,A0 semantics) picks the lane directly.
//  Sits between a serial/shared bus and parallel consumers in the CPU datapath.
// PARAMETERS
//  WIDTH   8   data width of din and of each output lane Q0..Q3
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  din          in   WIDTH  input sample
//  din_valid    in   1      din is a valid sample this cycle
//  sof          in   1      start of frame; meaningful only with din_valid, TDM mode
//  mode         in   1      0 = TDM rotate, 1 = addressed
//  sel          in   2      lane address in addressed mode (sel[1]=A1, sel[0]=A0)
//  Q0..Q3       out  WIDTH  registered output lanes
//  frame_valid  out  1      1-cycle pulse: Q0..Q3 hold a complete new TDM frame
//  slot         out  2      next TDM slot to be filled
//  locked       out  1      1 while FSM is in RUN
//  sync_err     out  1      1-cycle pulse on frame-alignment error
// BEHAVIOUR
//  - Reset (rst=1 at posedge): highest priority, including mid-frame.
//    Q0..Q3=0, staging=0, slot=0, frame_valid=0, sync_err=0, state=HUNT (locked=0).
//  - din_valid=0: no state, slot or lane change. frame_valid and sync_err return to 0.
//  - frame_valid and sync_err are registered. Each is high for exactly one cycle per event.
//  - TDM FSM (mode=0), states HUNT and RUN:
//    HUNT: samples without sof are dropped.
//      din_valid&sof: staging0<=din, slot<=1, go to RUN.
//    RUN, din_valid, slot in 1..2, sof=0: staging[slot]<=din, slot<=slot+1.
//    RUN, din_valid, slot=3, sof=0: complete the frame at this same edge:
//      Q0<=staging0, Q1<=staging1, Q2<=staging2, Q3<=din.
//      frame_valid<=1, slot<=0 (wrap), stay in RUN.
//    RUN, din_valid, slot=0, sof=1: staging0<=din, slot<=1 (normal frame start).
//    RUN, din_valid, slot=0, sof=0: sync_err<=1, sample dropped, go to HUNT, slot stays 0.
//    RUN, din_valid, slot!=0, sof=1: early sof.
//      sync_err<=1, partial frame discarded (Q unchanged).
//      staging0<=din, slot<=1, stay in RUN (immediate relock).
//  - Latency: Q0..Q3 and frame_valid change together, one edge after the slot-3 sample is presented.
//    Q holds the last complete frame until the next frame completes.
//  - Addressed mode (mode=1):
//    Each din_valid writes Q[sel]<=din at that edge. Other lanes hold.
//    sof is ignored. frame_valid and sync_err stay 0.
//  - Mode change: any cycle where mode differs from its registered previous value resets the FSM.
//    FSM goes to HUNT with slot=0, and staging is cleared. Q0..Q3 are retained.
//    A din_valid sample on that cycle is still handled per the new mode.
// TESTING
//  1. Reset, then TDM frame 11,22,33,44 (sof on 11) -> Q0..Q3=11,22,33,44; frame_valid one cycle; slot=0.
//  2. Same frame with din_valid gaps of 3 idle cycles -> identical Q. One frame_valid, only after 44.
//  3. RUN: 01,02 then sof with 0A,0B,0C,0D -> sync_err pulse at 0A. Q=0A,0B,0C,0D; 01/02 never reach Q.
//  4. Samples 55,66 with no sof after reset -> locked=0, Q stays 0, no pulses.
//     Next sof sample locks normally.
//  5. mode=1: sel=2 with din=A5, then sel=0 with din=5A -> Q2=A5, Q0=5A, Q1=Q3 hold.
//     frame_valid stays 0.
//  6. rst asserted after slot-2 sample -> all outputs 0, HUNT.
//     A following full frame with sof decodes correctly.

Source files
------------

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: spreads one sample stream over four registered lanes,
// either by a sof-locked rotating slot counter (TDM) or by a direct lane address.
module tdm_demux #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    input  logic             mode,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {StHunt, StRun} state_e;

    state_e           state_q, state_d, state_cur;
    logic [1:0]       slot_q, slot_d, slot_cur;
    logic [WIDTH-1:0] stage_q [3];
    logic [WIDTH-1:0] stage_d [3];
    logic [WIDTH-1:0] lane_q  [4];
    logic [WIDTH-1:0] lane_d  [4];
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;
    logic             mode_q;
    logic             mode_change;

    assign mode_change = (mode != mode_q);

    // A mode change restarts the FSM before this cycle's sample is handled.
    always_comb begin
        state_cur = mode_change ? StHunt : state_q;
        slot_cur  = mode_change ? 2'd0 : slot_q;
    end

    always_comb begin
        state_d       = state_cur;
        slot_d        = slot_cur;
        stage_d       = stage_q;
        lane_d        = lane_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        if (mode_change) begin
            stage_d = '{default: '0};
        end

        if (din_valid) begin
            if (mode) begin
                lane_d[sel] = din;
            end else begin
                unique case (state_cur)
                    StHunt: begin
                        if (sof) begin
                            stage_d[0] = din;
                            slot_d     = 2'd1;
                            state_d    = StRun;
                        end
                    end
                    StRun: begin
                        if (sof) begin
                            // Early sof drops the partial frame and relocks on this sample.
                            sync_err_d = (slot_cur != 2'd0);
                            stage_d[0] = din;
                            slot_d     = 2'd1;
                        end else if (slot_cur == 2'd0) begin
                            sync_err_d = 1'b1;
                            state_d    = StHunt;
                        end else if (slot_cur == 2'd3) begin
                            lane_d[0]     = stage_d[0];
                            lane_d[1]     = stage_d[1];
                            lane_d[2]     = stage_d[2];
                            lane_d[3]     = din;
                            frame_valid_d = 1'b1;
                            slot_d        = 2'd0;
                        end else begin
                            if (slot_cur == 2'd1) begin
                                stage_d[1] = din;
                            end else begin
                                stage_d[2] = din;
                            end
                            slot_d = slot_cur + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StHunt;
            slot_q        <= 2'd0;
            stage_q       <= '{default: '0};
            lane_q        <= '{default: '0};
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            mode_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            stage_q       <= stage_d;
            lane_q        <= lane_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            mode_q        <= mode;
        end
    end

    assign Q0          = lane_q[0];
    assign Q1          = lane_q[1];
    assign Q2          = lane_q[2];
    assign Q3          = lane_q[3];
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign slot        = slot_q;
    assign locked      = (state_q == StRun);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux with hand-computed expectations.
module tb_tdm_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       sof;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] Q0, Q1, Q2, Q3;
    logic       frame_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdm_demux #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .mode       (mode),
        .sel        (sel),
        .Q0         (Q0),
        .Q1         (Q1),
        .Q2         (Q2),
        .Q3         (Q3),
        .frame_valid(frame_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
        check({tag, ".Q0"}, Q0, e0);
        check({tag, ".Q1"}, Q1, e1);
        check({tag, ".Q2"}, Q2, e2);
        check({tag, ".Q3"}, Q3, e3);
    endtask

    // Present one cycle of input, then sample just after the edge.
    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst = 1'b1;
        mode = 1'b0;
        sel = 2'd0;
        din_valid = 1'b0;
        sof = 1'b0;
        din = 8'h00;
        idle(2);
        rst = 1'b0;

        // Reset state
        check_q("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("rst.locked", locked, 0);
        check("rst.slot", slot, 0);
        check("rst.fv", frame_valid, 0);
        check("rst.se", sync_err, 0);

        // 1: basic frame
        drive(1, 1, 8'h11);
        check("t1.locked", locked, 1);
        check("t1.slot1", slot, 1);
        drive(1, 0, 8'h22);
        drive(1, 0, 8'h33);
        check("t1.slot3", slot, 3);
        check("t1.fv_early", frame_valid, 0);
        check_q("t1.pre", 8'h00, 8'h00, 8'h00, 8'h00);
        drive(1, 0, 8'h44);
        check_q("t1", 8'h11, 8'h22, 8'h33, 8'h44);
        check("t1.fv", frame_valid, 1);
        check("t1.slot0", slot, 0);
        idle(1);
        check("t1.fv_pulse", frame_valid, 0);

        // 2: same frame with 3-cycle gaps
        drive(1, 1, 8'h11);
        idle(3);
        check("t2.slot_hold", slot, 1);
        check("t2.fv_gap", frame_valid, 0);
        drive(1, 0, 8'h22);
        idle(3);
        drive(1, 0, 8'h33);
        idle(3);
        check("t2.fv_gap3", frame_valid, 0);
        drive(1, 0, 8'h44);
        check("t2.fv", frame_valid, 1);
        check_q("t2", 8'h11, 8'h22, 8'h33, 8'h44);
        idle(1);
        check("t2.fv_pulse", frame_valid, 0);

        // 3: early sof relocks
        drive(1, 1, 8'h01);
        drive(1, 0, 8'h02);
        drive(1, 1, 8'h0A);
        check("t3.se", sync_err, 1);
        check("t3.slot", slot, 1);
        check("t3.locked", locked, 1);
        check_q("t3.hold", 8'h11, 8'h22, 8'h33, 8'h44);
        drive(1, 0, 8'h0B);
        check("t3.se_pulse", sync_err, 0);
        drive(1, 0, 8'h0C);
        drive(1, 0, 8'h0D);
        check_q("t3", 8'h0A, 8'h0B, 8'h0C, 8'h0D);
        check("t3.fv", frame_valid, 1);

        // Missing sof at slot 0 drops to HUNT
        drive(1, 0, 8'h77);
        check("t3b.se", sync_err, 1);
        check("t3b.locked", locked, 0);
        check("t3b.slot", slot, 0);

        // 4: no sof after reset stays in HUNT
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        drive(1, 0, 8'h55);
        drive(1, 0, 8'h66);
        check("t4.locked", locked, 0);
        check("t4.fv", frame_valid, 0);
        check("t4.se", sync_err, 0);
        check_q("t4.hold", 8'h00, 8'h00, 8'h00, 8'h00);
        drive(1, 1, 8'h21);
        check("t4.lock", locked, 1);
        drive(1, 0, 8'h32);
        drive(1, 0, 8'h43);
        drive(1, 0, 8'h54);
        check_q("t4", 8'h21, 8'h32, 8'h43, 8'h54);

        // 5: addressed mode, sof ignored
        mode = 1'b1;
        sel = 2'd2;
        drive(1, 1, 8'hA5);
        check("t5.locked", locked, 0);
        sel = 2'd0;
        drive(1, 1, 8'h5A);
        check_q("t5", 8'h5A, 8'h32, 8'hA5, 8'h54);
        check("t5.fv", frame_valid, 0);
        check("t5.se", sync_err, 0);
        sel = 2'd3;
        drive(0, 0, 8'hEE);
        check("t5.novalid", Q3, 8'h54);

        // 6: reset mid-frame, then a clean frame
        mode = 1'b0;
        idle(1);
        check("t6.hunt", locked, 0);
        drive(1, 1, 8'h61);
        drive(1, 0, 8'h62);
        drive(1, 0, 8'h63);
        check("t6.slot3", slot, 3);
        rst = 1'b1;
        drive(1, 0, 8'h64);
        rst = 1'b0;
        check_q("t6.rst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("t6.rst_slot", slot, 0);
        check("t6.rst_locked", locked, 0);
        check("t6.rst_fv", frame_valid, 0);
        drive(1, 1, 8'h71);
        drive(1, 0, 8'h72);
        drive(1, 0, 8'h73);
        drive(1, 0, 8'h74);
        check_q("t6", 8'h71, 8'h72, 8'h73, 8'h74);
        check("t6.fv", frame_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
